// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: elastic valid/ready inter-stage register, DEPTH-entry circular buffer.
// Latency: 1 cycle in->out; 0 cycles through an empty register when PIPE_BYPASS_EN is defined.
// Backpressure: in_ready drops when full, in FLUSH or in RST; it never depends on out_ready.
// Optional feature macro: PIPE_BYPASS_EN (combinational in->out path when empty).

module pipe_elastic_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] max_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Payload storage is intentionally not reset; out_data is only meaningful with out_valid.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          push, pop, bypass, stored_vld;

  // Ready only looks at local occupancy: a pop in the same cycle never opens a push slot.
  assign in_ready   = ~RST & ~FLUSH & (count < FULL);
  assign stored_vld = (count != '0) & ~FLUSH;

`ifdef PIPE_BYPASS_EN
  // Empty register with a consumer ready: hand the payload straight through, no write.
  assign bypass    = (count == '0) & in_valid & out_ready & ~FLUSH & ~RST;
  assign out_valid = stored_vld | bypass;
  assign out_data  = bypass ? in_data : mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = stored_vld;
  assign out_data  = mem[rd_ptr];
`endif

  // A bypassed beat is consumed downstream, so it must not also land in storage.
  assign push = in_valid & in_ready & ~bypass;
  assign pop  = stored_vld & out_ready;

  // Next-state for pointers and occupancy; flush wins over any handshake.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (FLUSH) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Control state: pointers, occupancy and its high-water mark.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt > max_count) begin
        max_count <= count_nxt;
      end
    end
  end

  // Payload write; a push is never accepted during FLUSH or RST since in_ready is low.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
